// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
//
// Purpose:
//   Walks a register file from FIRST_REG to LAST_REG through a combinational
//   read port and streams each register out as one valid/ready beat that
//   carries its value and index. An optional trailing checksum beat can be
//   compiled in.
//
// Parameters:
//   FIRST_REG - first register index dumped (5-bit)
//   LAST_REG  - last register index dumped; FIRST_REG > LAST_REG is illegal
//
// Configuration macro:
//   REG_DUMP_CHECKSUM_EN - when defined, every accepted register beat is XORed
//                          into a 32-bit checksum. The checksum goes out as one
//                          extra beat (index 0, out_last=1) after LAST_REG.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   asynchronous active-high reset
//   start     in   request a dump (only looked at while idle)
//   rf_addr   out  register-file read address (non-zero only while fetching)
//   rf_rd     in   register-file read data for rf_addr, same cycle
//   out_valid out  output beat valid
//   out_ready in   consumer accepts the beat
//   out_data  out  beat payload
//   out_index out  register index of the beat
//   out_last  out  final beat of the dump
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module reg_dump_reader #(
    parameter logic [4:0] FIRST_REG = 5'd0,
    parameter logic [4:0] LAST_REG  = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        CSUM,
        DONE
    } state_t;

    state_t     state;
    logic [4:0] ptr;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    // Single registered FSM. Every output is a flop. rf_addr is loaded with
    // the pointer value on the edge that enters FETCH, so the read port sees
    // the right address for the whole FETCH cycle. It is cleared again on
    // the edge that leaves FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 5'd0;
            rf_addr   <= 5'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_index <= 5'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            checksum  <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    out_valid <= 1'b0;
                    if (start) begin
                        ptr     <= FIRST_REG;
                        rf_addr <= FIRST_REG;
                        busy    <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        checksum <= 32'd0;
`endif
                        state   <= FETCH;
                    end
                end

                FETCH: begin
                    out_data  <= rf_rd;
                    out_index <= ptr;
`ifdef REG_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= (ptr == LAST_REG);
`endif
                    out_valid <= 1'b1;
                    rf_addr   <= 5'd0;
                    state     <= SEND;
                end

                // The payload registers are only written on a handshake, so
                // they stay stable while the consumer stalls.
                SEND: begin
                    if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        checksum <= checksum ^ out_data;
`endif
                        if (ptr < LAST_REG) begin
                            ptr       <= ptr + 5'd1;
                            rf_addr   <= ptr + 5'd1;
                            out_valid <= 1'b0;
                            state     <= FETCH;
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // The checksum register does not yet include
                            // this last beat, so fold it in here.
                            // out_valid stays high into the checksum beat.
                            out_data  <= checksum ^ out_data;
                            out_index <= 5'd0;
                            out_last  <= 1'b1;
                            state     <= CSUM;
`else
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
`endif
                        end
                    end
                end

`ifdef REG_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    rf_addr   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_reader
//
// Directed bench for reg_dump_reader. Instances:
//   [0] default range 0..31, register file returns index*0x10
//   [1] range 6..9, x6=0x0000000A, x9=0x00000020, all others 0
//   [2] range 1..2, x1=0xF0F0F0F0, x2=0x0F0F0F0F (only when
//       REG_DUMP_CHECKSUM_EN is defined)
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// at the same point, where they are stable.
// -----------------------------------------------------------------------------
module tb_reg_dump_reader;

    logic        clk;
    logic        rst;
    logic        start_s   [3];
    logic        ready_s   [3];
    logic [4:0]  rf_addr_s [3];
    logic [31:0] rf_rd_s   [3];
    logic        valid_s   [3];
    logic [31:0] data_s    [3];
    logic [4:0]  index_s   [3];
    logic        last_s    [3];
    logic        busy_s    [3];
    logic        done_s    [3];

    int n_checks = 0;
    int n_fail   = 0;

    reg_dump_reader dut_a (
        .clk(clk), .rst(rst), .start(start_s[0]),
        .rf_addr(rf_addr_s[0]), .rf_rd(rf_rd_s[0]),
        .out_valid(valid_s[0]), .out_ready(ready_s[0]),
        .out_data(data_s[0]), .out_index(index_s[0]), .out_last(last_s[0]),
        .busy(busy_s[0]), .done(done_s[0])
    );

    reg_dump_reader #(.FIRST_REG(5'd6), .LAST_REG(5'd9)) dut_b (
        .clk(clk), .rst(rst), .start(start_s[1]),
        .rf_addr(rf_addr_s[1]), .rf_rd(rf_rd_s[1]),
        .out_valid(valid_s[1]), .out_ready(ready_s[1]),
        .out_data(data_s[1]), .out_index(index_s[1]), .out_last(last_s[1]),
        .busy(busy_s[1]), .done(done_s[1])
    );

`ifdef REG_DUMP_CHECKSUM_EN
    reg_dump_reader #(.FIRST_REG(5'd1), .LAST_REG(5'd2)) dut_c (
        .clk(clk), .rst(rst), .start(start_s[2]),
        .rf_addr(rf_addr_s[2]), .rf_rd(rf_rd_s[2]),
        .out_valid(valid_s[2]), .out_ready(ready_s[2]),
        .out_data(data_s[2]), .out_index(index_s[2]), .out_last(last_s[2]),
        .busy(busy_s[2]), .done(done_s[2])
    );
    assign rf_rd_s[2] = (rf_addr_s[2] == 5'd1) ? 32'hF0F0F0F0 :
                        (rf_addr_s[2] == 5'd2) ? 32'h0F0F0F0F : 32'h0;
`else
    assign rf_addr_s[2] = 5'd0;
    assign rf_rd_s[2]   = 32'h0;
    assign valid_s[2]   = 1'b0;
    assign data_s[2]    = 32'h0;
    assign index_s[2]   = 5'd0;
    assign last_s[2]    = 1'b0;
    assign busy_s[2]    = 1'b0;
    assign done_s[2]    = 1'b0;
`endif

    // Register-file contents for each instance
    assign rf_rd_s[0] = {23'd0, rf_addr_s[0], 4'd0};
    assign rf_rd_s[1] = (rf_addr_s[1] == 5'd6) ? 32'h0000000A :
                        (rf_addr_s[1] == 5'd9) ? 32'h00000020 : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected payload for register idx of instance which
    function automatic logic [31:0] exp_data(input int which, input int idx);
        case (which)
            0: return 32'(idx * 16);
            1: return (idx == 6) ? 32'h0000000A : (idx == 9) ? 32'h00000020 : 32'h0;
            2: return (idx == 1) ? 32'hF0F0F0F0 : (idx == 2) ? 32'h0F0F0F0F : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic st, input logic rdy);
        start_s[which] = st;
        ready_s[which] = rdy;
    endtask

    // Start a dump on one instance and follow it to its done pulse. Stalls
    // the consumer for 5 cycles on stall_idx, and re-pulses start while
    // restart_idx is on the output.
    task automatic run_dump(input int which, input int first, input int last,
                            input int stall_idx, input int restart_idx);
        int          exp_idx;
        int          beats;
        int          dones;
        int          cycles;
        int          exp_beats;
        logic [31:0] exp_csum;
        logic [31:0] hold_data;
        logic [4:0]  hold_idx;
        bit          finished;
        bit          stalled;
        bit          csum_pending;
        logic        exp_last;

        exp_idx = first; beats = 0; dones = 0; cycles = 0;
        exp_csum = 32'h0; finished = 0; stalled = 0; csum_pending = 0;
        exp_beats = last - first + 1;
`ifdef REG_DUMP_CHECKSUM_EN
        exp_beats = exp_beats + 1;
`endif

        applyStimulus(which, 1'b1, 1'b1);
        tick();
        applyStimulus(which, 1'b0, 1'b1);
        checkOutput("fetch_valid", 32'(valid_s[which]), 32'd0);
        checkOutput("fetch_busy", 32'(busy_s[which]), 32'd1);
        checkOutput("fetch_rf_addr", 32'(rf_addr_s[which]), 32'(first));
        tick();
        checkOutput("latency_valid", 32'(valid_s[which]), 32'd1);

        while (!finished && cycles < 400) begin
            if (done_s[which]) begin
                dones++;
                finished = 1;
            end else begin
                if (valid_s[which]) begin
                    if (!csum_pending && int'(index_s[which]) == stall_idx && !stalled) begin
                        stalled   = 1;
                        hold_data = data_s[which];
                        hold_idx  = index_s[which];
                        applyStimulus(which, 1'b0, 1'b0);
                        for (int k = 0; k < 5; k++) begin
                            tick();
                            checkOutput("stall_valid", 32'(valid_s[which]), 32'd1);
                            checkOutput("stall_data", data_s[which], hold_data);
                            checkOutput("stall_index", 32'(index_s[which]), 32'(hold_idx));
                        end
                        applyStimulus(which, 1'b0, 1'b1);
                    end
                    if (!csum_pending && int'(index_s[which]) == restart_idx)
                        applyStimulus(which, 1'b1, 1'b1);
                    if (!csum_pending) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        exp_last = 1'b0;
`else
                        exp_last = (exp_idx == last);
`endif
                        checkOutput("beat_data", data_s[which], exp_data(which, exp_idx));
                        checkOutput("beat_index", 32'(index_s[which]), 32'(exp_idx));
                        checkOutput("beat_last", 32'(last_s[which]), 32'(exp_last));
                        exp_csum = exp_csum ^ exp_data(which, exp_idx);
`ifdef REG_DUMP_CHECKSUM_EN
                        if (exp_idx == last) csum_pending = 1;
`endif
                        exp_idx++;
                    end else begin
                        checkOutput("csum_data", data_s[which], exp_csum);
                        checkOutput("csum_index", 32'(index_s[which]), 32'd0);
                        checkOutput("csum_last", 32'(last_s[which]), 32'd1);
                        csum_pending = 0;
                    end
                    beats++;
                end
                tick();
                applyStimulus(which, 1'b0, 1'b1);
                cycles++;
            end
        end

        checkOutput("done_seen", 32'(finished), 32'd1);
        checkOutput("beat_count", 32'(beats), 32'(exp_beats));
        checkOutput("cycle_count", 32'(cycles), 32'(2 * (last - first + 1) - 1 + (exp_beats - (last - first + 1))));
        checkOutput("done_count", 32'(dones), 32'd1);
        checkOutput("done_busy", 32'(busy_s[which]), 32'd1);
        tick();
        checkOutput("done_clear", 32'(done_s[which]), 32'd0);
        checkOutput("idle_busy", 32'(busy_s[which]), 32'd0);
        checkOutput("idle_rf_addr", 32'(rf_addr_s[which]), 32'd0);
        checkOutput("idle_valid", 32'(valid_s[which]), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag, input int which);
        checkOutput({tag, "_rf_addr"}, 32'(rf_addr_s[which]), 32'd0);
        checkOutput({tag, "_valid"}, 32'(valid_s[which]), 32'd0);
        checkOutput({tag, "_data"}, data_s[which], 32'd0);
        checkOutput({tag, "_index"}, 32'(index_s[which]), 32'd0);
        checkOutput({tag, "_last"}, 32'(last_s[which]), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy_s[which]), 32'd0);
        checkOutput({tag, "_done"}, 32'(done_s[which]), 32'd0);
    endtask

    initial begin
        bit found;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b1);
        #3;
        check_zero_outputs("reset", 0);
        check_zero_outputs("reset_b", 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_zero_outputs("post_reset", 0);

        $display("[TB] full default dump");
        run_dump(0, 0, 31, -1, -1);

        $display("[TB] range 6..9 dump");
        run_dump(1, 6, 9, -1, -1);

        $display("[TB] consumer stall on index 3");
        run_dump(0, 0, 31, 3, -1);

        $display("[TB] start re-pulsed mid-dump");
        run_dump(0, 0, 31, -1, 12);

        $display("[TB] asynchronous reset during index 10");
        applyStimulus(0, 1'b1, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 1'b1);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (valid_s[0] && index_s[0] == 5'd10) found = 1;
            else tick();
        end
        checkOutput("reach_index10", 32'(found), 32'd1);
        checkOutput("index10_data", data_s[0], 32'h000000A0);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_reset", 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero_outputs("reset_hold", 0);
        tick();
        checkOutput("reset_no_done", 32'(done_s[0]), 32'd0);
        checkOutput("reset_idle_busy", 32'(busy_s[0]), 32'd0);
        run_dump(0, 0, 31, -1, -1);

`ifdef REG_DUMP_CHECKSUM_EN
        $display("[TB] checksum beat on range 1..2");
        run_dump(2, 1, 2, -1, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter FIRST_REG, default 0, is the first register index read (5-bit).
REQ-002 Parameter LAST_REG, default 31, is the last register index read; FIRST_REG > LAST_REG is an illegal configuration.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: request a dump; sampled only in IDLE.
REQ-006 Port rf_addr, output, 5: read address driven to a combinational register-file read port.
REQ-007 Port rf_rd, input, 32: read data returned by the register file in the same cycle as rf_addr.
REQ-008 Port out_valid, output, 1: the output beat is valid.
REQ-009 Port out_ready, input, 1: the consumer accepts the beat.
REQ-010 Port out_data, output, 32: beat payload.
REQ-011 Port out_index, output, 5: register index of the beat.
REQ-012 Port out_last, output, 1: marks the final beat of the dump.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle pulse after the final beat is accepted.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, SEND, CSUM and DONE.
REQ-016 In IDLE, start=1 SHALL load ptr=FIRST_REG and clear the checksum, then move to FETCH on the next edge.
REQ-017 In FETCH, rf_addr SHALL equal ptr, and the FSM SHALL capture rf_rd into out_data and ptr into out_index, then move to SEND.
REQ-018 In SEND, out_valid SHALL be 1, and out_data and out_index SHALL be held stable until out_valid and out_ready are both high.
REQ-019 On a SEND handshake with ptr<LAST_REG, ptr SHALL increment and the FSM SHALL return to FETCH.
REQ-020 On a SEND handshake with ptr==LAST_REG, the FSM SHALL move to CSUM if the macro is defined, else to DONE.
REQ-021 Throughput SHALL be one beat per 2 cycles minimum, with start-to-first-out_valid latency of 2 cycles.
REQ-022 DONE SHALL assert done for exactly one cycle and then return to IDLE; out_valid SHALL be 0 in DONE.
REQ-023 A start asserted while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-024 The FSM SHALL perform no index wrap-around: ptr never exceeds LAST_REG, and FIRST_REG==LAST_REG yields exactly one register beat.
REQ-025 While out_valid=0, out_ready SHALL be ignored.
REQ-026 In IDLE and DONE, rf_addr SHALL be 0.
REQ-027 The FSM SHALL not decide which register reads are valid: index 0 is dumped as whatever rf_rd returns.

Reset
REQ-028 rst=1 SHALL immediately force the state to IDLE, at any time including mid-dump, and the dump SHALL be abandoned with no done pulse.
REQ-029 Reset SHALL force ptr=0 and checksum=0.
REQ-030 Reset SHALL force these output values: rf_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0.

Configuration
REQ-031 Macro REG_DUMP_CHECKSUM_EN, when defined, SHALL make every accepted register beat XOR its out_data into a 32-bit checksum.
REQ-032 With REG_DUMP_CHECKSUM_EN defined, CSUM SHALL present one extra beat with out_data=checksum, out_index=0 and out_last=1, held until handshake, then move to DONE.
REQ-033 With REG_DUMP_CHECKSUM_EN defined, out_last SHALL be 0 on all register beats.
REQ-034 Without REG_DUMP_CHECKSUM_EN, there SHALL be no checksum logic and no CSUM beat, and out_last=1 on the LAST_REG beat only.

Verification
REQ-035 Bench scenario, default params, out_ready=1, rf_rd=index*0x10, pulse start: 32 beats, out_data 0x0,0x10..0x1F0 with out_index 0..31, out_valid first seen 2 cycles after start, done pulse once.
REQ-036 Bench scenario, FIRST_REG=6, LAST_REG=9, rf_rd x6=0x0000000A and x9=0x00000020, others 0: 4 beats (0xA,0,0,0x20), out_last only on index 9 (macro off).
REQ-037 Bench scenario, out_ready low for 5 cycles during the beat of index 3: out_valid stays 1, out_data/out_index stable, no skipped or duplicated index.
REQ-038 Bench scenario, start pulsed again mid-dump: ignored, beat count unchanged, single done.
REQ-039 Bench scenario, rst asserted asynchronously during SEND of index 10: outputs zero before the next edge; after release, a new start dumps again from FIRST_REG.
REQ-040 Bench scenario, REG_DUMP_CHECKSUM_EN defined, FIRST_REG=1, LAST_REG=2, rf_rd x1=0xF0F0F0F0 and x2=0x0F0F0F0F: third beat out_data=0xFFFFFFFF, out_index=0, out_last=1, then done.
